fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Each accepted entry holds an instruction word, that instruction's PC and its PC+1 link value, in FIFO order.
- Provides valid/ready backpressure: fetch's PC enable is driven from f_ready, so the PC holds while the queue is full.
- A flush (branch taken, i.e. PC overwrite) discards all queued instructions.

Parameters:
- WIDTH, 32, width of instruction and PC fields.
- DEPTH, 2, number of entries; power of two, 2..8.
- CW, 2, occupancy width; must satisfy 2^CW > DEPTH.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- clr  in  1  reset: asynchronous and active-low (clr=0 resets).
- f_valid  in  1  fetch presents an instruction this cycle.
- f_insn  in  WIDTH  instruction word from instruction memory.
- f_pc  in  WIDTH  PC of f_insn.
- f_pc_next  in  WIDTH  PC+1 of f_insn.
- f_ready  out  1  queue accepts an instruction this cycle; drives fetch enable.
- flush  in  1  discard all entries (branch/jump resolved).
- d_valid  out  1  head entry is valid.
- d_ready  in  1  decode consumes the head this cycle.
- d_insn  out  WIDTH  head instruction; 0 (NOP) when d_valid=0.
- d_pc  out  WIDTH  head PC; 0 when d_valid=0.
- d_pc_next  out  WIDTH  head PC+1; 0 when d_valid=0.
- count  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (clr=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, all storage cleared to 0.
  - d_valid=0; d_insn, d_pc, d_pc_next = 0.
  - f_ready forced 0 while clr=0; 1 on the first cycle after release.
- Reset mid-operation discards all entries immediately; no partial state survives.
- Combinational outputs:
  - f_ready = clr & (count != DEPTH).
  - d_valid = (count != 0).
  - d_* data come from storage[rd_ptr], gated to 0 when d_valid=0.
- No combinational path exists from any input to any output except clr→f_ready.
- push = f_valid & f_ready & ~flush.
- pop = d_valid & d_ready & ~flush.
- On each rising edge, priority is: flush, then push/pop.
  - flush=1: count=0, wr_ptr=0, rd_ptr=0. Any same-cycle push/pop is ignored. Storage contents are don't-care but outputs stay gated to 0.
  - push only: storage[wr_ptr] takes {f_insn, f_pc, f_pc_next}; wr_ptr+1 mod DEPTH; count+1.
  - pop only: rd_ptr+1 mod DEPTH; count-1.
  - push and pop: both pointers advance; count unchanged.
- Latency: an instruction pushed at edge N is visible on d_* (d_valid=1) in the cycle after edge N, provided the queue was empty or it reaches the head.
- Full (count=DEPTH): f_ready=0 even if decode pops in the same cycle; no full-cycle pass-through. Throughput is recovered on the next cycle.
- Empty (count=0): d_valid=0 and outputs are NOP; d_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; order is preserved across wrap.
- f_valid=0 with f_ready=1 performs no write; garbage on f_* is never stored.
- Overflow and underflow are impossible by construction; the bench asserts count never exceeds DEPTH.
- Fetch contract: fetch advances its PC only when f_ready=1; f_* stay stable while f_ready=0.

Test Plan:
- Reset/idle: hold clr=0 3 cycles then release, f_valid=0 → count=0, d_valid=0, d_insn=0, f_ready=0 during reset, 1 after.
- Single push: f_valid=1, f_insn=0x00A00093, f_pc=0x10, f_pc_next=0x11 for one cycle, d_ready=0 → next cycle d_valid=1, d_insn=0x00A00093, d_pc=0x10, d_pc_next=0x11, count=1.
- Fill and backpressure (DEPTH=2): push pc 0x20, 0x21, 0x22 on consecutive cycles with d_ready=0 → count=2 and f_ready=0 after the second push. The third instruction is not stored. Head remains 0x20.
- Streaming with wrap: d_ready=1 constantly, 10 pushes pc 0x00..0x09 → d_pc sequence 0x00..0x09 in order, one per cycle after 1-cycle latency, no gaps, count ≤1.
- Flush priority: queue holding 0x30, 0x31; assert flush with f_valid=1 (pc 0x32) and d_ready=1 → next cycle count=0, d_valid=0, d_insn=0. Pc 0x32 is absent; a later push of 0x40 appears as the head.
- Async reset mid-stream: queue holding 2 entries, drop clr between clock edges → count, d_valid and f_ready go to 0 immediately without a clock edge. After release the queue is empty and accepts new pushes.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode.
// Each entry carries {insn, pc, pc_next}. Valid/ready handshake on both sides.
// Flush discards every queued entry. Head data reads as 0 (NOP) while the queue is empty.
module fetch_decode_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             f_valid,
    input  logic [WIDTH-1:0] f_insn,
    input  logic [WIDTH-1:0] f_pc,
    input  logic [WIDTH-1:0] f_pc_next,
    output logic             f_ready,
    input  logic             flush,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [WIDTH-1:0] d_insn,
    output logic [WIDTH-1:0] d_pc,
    output logic [WIDTH-1:0] d_pc_next,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] insn_q [DEPTH];
    logic [WIDTH-1:0] insn_d [DEPTH];
    logic [WIDTH-1:0] pc_q   [DEPTH];
    logic [WIDTH-1:0] pc_d   [DEPTH];
    logic [WIDTH-1:0] pcn_q  [DEPTH];
    logic [WIDTH-1:0] pcn_d  [DEPTH];
    logic             push;
    logic             pop;

    // Handshake decode. The full flag depends only on state, so there is no full-cycle pass-through.
    always_comb begin
        f_ready   = clr & (count_q != CW'(DEPTH));
        d_valid   = (count_q != '0);
        push      = f_valid & f_ready & ~flush;
        pop       = d_valid & d_ready & ~flush;
        d_insn    = d_valid ? insn_q[rd_ptr_q] : '0;
        d_pc      = d_valid ? pc_q[rd_ptr_q]   : '0;
        d_pc_next = d_valid ? pcn_q[rd_ptr_q]  : '0;
        count     = count_q;
    end

    // Next-state: flush wins over push/pop. Pointers wrap at power-of-two DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        insn_d   = insn_q;
        pc_d     = pc_q;
        pcn_d    = pcn_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                insn_d[wr_ptr_q] = f_insn;
                pc_d[wr_ptr_q]   = f_pc;
                pcn_d[wr_ptr_q]  = f_pc_next;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers. Reset is asynchronous and also clears storage.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                insn_q[i] <= '0;
                pc_q[i]   <= '0;
                pcn_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            insn_q   <= insn_d;
            pc_q     <= pc_d;
            pcn_q    <= pcn_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue.
// A queue-based reference model tracks the expected contents.
module tb_fetch_decode_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef struct packed {
        logic [WIDTH-1:0] insn;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pcn;
    } item_t;

    logic             clock = 1'b0;
    logic             clr;
    logic             f_valid;
    logic [WIDTH-1:0] f_insn;
    logic [WIDTH-1:0] f_pc;
    logic [WIDTH-1:0] f_pc_next;
    logic             f_ready;
    logic             flush;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] d_insn;
    logic [WIDTH-1:0] d_pc;
    logic [WIDTH-1:0] d_pc_next;
    logic [CW-1:0]    count;

    int    n_cmp  = 0;
    int    n_fail = 0;
    item_t mq[$];

    fetch_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .clr(clr),
        .f_valid(f_valid), .f_insn(f_insn), .f_pc(f_pc), .f_pc_next(f_pc_next),
        .f_ready(f_ready), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_insn(d_insn), .d_pc(d_pc), .d_pc_next(d_pc_next), .count(count)
    );

    always #5 clock = ~clock;

    // Occupancy must never exceed DEPTH.
    always @(negedge clock) begin
        if (clr === 1'b1) begin
            n_cmp++;
            if (count > CW'(DEPTH)) begin
                n_fail++;
                $display("FAIL count_bound: count=%0d limit=%0d", count, DEPTH);
            end
        end
    end

    // Advance one clock and update the reference model from the queue's rules.
    task automatic tick();
        bit    do_push, do_pop;
        item_t it;
        do_push = f_valid && clr && (mq.size() != DEPTH) && !flush;
        do_pop  = d_ready && (mq.size() != 0) && !flush;
        it      = '{insn: f_insn, pc: f_pc, pcn: f_pc_next};
        @(posedge clock);
        if (!clr || flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(it);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                         input bit rdy, input bit fl);
        f_valid   = v;
        f_insn    = insn;
        f_pc      = pc;
        f_pc_next = pc + 32'd1;
        d_ready   = rdy;
        flush     = fl;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        drive(1'b0, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (f_ready !== 1'b0 || count !== 2'd0 || d_valid !== 1'b0 || d_insn !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_hold: f_ready=%b count=%0d d_valid=%b d_insn=%h want 0/0/0/0",
                         f_ready, count, d_valid, d_insn);
            end
        end
        clr = 1'b1;
        tick();
        n_cmp++;
        if (f_ready !== 1'b1 || count !== 2'd0 || d_valid !== 1'b0 || d_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: f_ready=%b count=%0d d_valid=%b d_pc=%h want 1/0/0/0",
                     f_ready, count, d_valid, d_pc);
        end
    endtask

    task automatic test_single_push();
        drive(1'b1, 32'h00A0_0093, 32'h10, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'hFFFF_FFFF, 32'h99, 1'b0, 1'b0);
        n_cmp++;
        if (d_valid !== 1'b1 || d_insn !== 32'h00A0_0093 || d_pc !== 32'h10 ||
            d_pc_next !== 32'h11 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL single_push: v=%b insn=%h pc=%h pcn=%h cnt=%0d want 1/00a00093/10/11/1",
                     d_valid, d_insn, d_pc, d_pc_next, count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (d_valid !== 1'b0 || count !== 2'd0 || d_insn !== 32'd0) begin
            n_fail++;
            $display("FAIL single_pop: v=%b cnt=%0d insn=%h want 0/0/0", d_valid, count, d_insn);
        end
    endtask

    task automatic test_fill_backpressure();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'h20 + 32'(i), 1'b0, 1'b0);
            tick();
            if (i == 1) begin
                n_cmp++;
                if (count !== 2'd2 || f_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_full: count=%0d f_ready=%b want 2/0", count, f_ready);
                end
            end
        end
        n_cmp++;
        if (count !== 2'd2 || d_pc !== 32'h20 || d_insn !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL fill_head: count=%0d d_pc=%h d_insn=%h want 2/20/a0000000", count, d_pc, d_insn);
        end
        // Full with a pop: still no accept this cycle.
        drive(1'b1, 32'hA000_0002, 32'h22, 1'b1, 1'b0);
        n_cmp++;
        if (f_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_ready: f_ready=%b want 0", f_ready);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (d_pc !== 32'h21 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL drain_second: d_pc=%h count=%0d want 21/1", d_pc, count);
        end
        tick();
        n_cmp++;
        if (d_valid !== 1'b0 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL drain_empty: d_valid=%b count=%0d want 0/0 (pc 22 must not be stored)", d_valid, count);
        end
    endtask

    task automatic test_streaming_wrap();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hB000_0000 + 32'(i), 32'(i), 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (d_valid !== 1'b1 || d_pc !== 32'(i) || d_insn !== 32'hB000_0000 + 32'(i) || count > 2'd1) begin
                n_fail++;
                $display("FAIL stream[%0d]: v=%b d_pc=%h insn=%h count=%0d want 1/%h/%h/<=1",
                         i, d_valid, d_pc, d_insn, count, i, 32'hB000_0000 + 32'(i));
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (d_valid !== 1'b0 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_end: d_valid=%b count=%0d want 0/0", d_valid, count);
        end
    endtask

    task automatic test_flush_priority();
        drive(1'b1, 32'hC000_0030, 32'h30, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC000_0031, 32'h31, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC000_0032, 32'h32, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (count !== 2'd0 || d_valid !== 1'b0 || d_insn !== 32'd0 || d_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL flush: count=%0d v=%b insn=%h pc=%h want 0/0/0/0", count, d_valid, d_insn, d_pc);
        end
        drive(1'b1, 32'hC000_0040, 32'h40, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (d_pc !== 32'h40 || d_pc_next !== 32'h41 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL flush_after: d_pc=%h pcn=%h count=%0d want 40/41/1", d_pc, d_pc_next, count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'hD000_0000, 32'h50, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hD000_0001, 32'h51, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        clr = 1'b0;
        mq.delete();
        #1;
        n_cmp++;
        if (count !== 2'd0 || d_valid !== 1'b0 || f_ready !== 1'b0 || d_insn !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d v=%b f_ready=%b insn=%h want 0/0/0/0",
                     count, d_valid, f_ready, d_insn);
        end
        tick();
        tick();
        clr = 1'b1;
        #1;
        n_cmp++;
        if (f_ready !== 1'b1 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL async_release: f_ready=%b count=%0d want 1/0", f_ready, count);
        end
        drive(1'b1, 32'hD000_0060, 32'h60, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (d_pc !== 32'h60 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL async_repush: d_pc=%h count=%0d want 60/1", d_pc, count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pc = 32'h100;
        bit          v  = 1'b0;
        item_t       h;
        for (int c = 0; c < 400; c++) begin
            // Fetch holds f_* while stalled; only a new fetch changes them.
            if (!v || f_ready) begin
                v  = ($urandom_range(0, 3) != 0);
                pc = pc + 32'd1;
            end
            drive(v, $urandom, pc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            if (f_valid && !f_ready) f_insn = 32'hE000_0000 ^ pc;
            tick();
            h = (mq.size() != 0) ? mq[0] : '0;
            n_cmp++;
            if (count !== CW'(mq.size()) || d_valid !== (mq.size() != 0) ||
                f_ready !== (mq.size() != DEPTH) ||
                d_insn !== h.insn || d_pc !== h.pc || d_pc_next !== h.pcn) begin
                n_fail++;
                $display("FAIL random[%0d]: cnt=%0d v=%b rdy=%b insn=%h pc=%h pcn=%h want cnt=%0d insn=%h pc=%h pcn=%h",
                         c, count, d_valid, f_ready, d_insn, d_pc, d_pc_next,
                         mq.size(), h.insn, h.pc, h.pcn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_backpressure();
        test_streaming_wrap();
        test_flush_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
